// File: rtl/morse_sequence_keyer.sv
// morse_sequence_keyer
//   Plays one encoded Morse sequence as a timed key signal. Elements are
//   sent slot0 first using standard unit timing (dot = 1 unit,
//   dash = 3 units, inter-element gap = 1 unit). The trailing letter gap
//   (3 units) or word gap (7 units) follows the last element.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort back to IDLE (wins over accept)
//   enc_seq    five 2-bit slots, [9:8] sent first; 00 dot, 01 dash, 1x empty
//   word_end   1 = word gap follows, 0 = letter gap follows
//   seq_valid  enc_seq/word_end valid
//   seq_ready  block can accept a sequence
//   key        registered key output, 1 = mark
//   busy       sequence in progress (first element cycle through done cycle)
//   done       one-cycle pulse on the last trailing-gap cycle
module morse_sequence_keyer #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = $clog2(7 * UNIT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [9:0] enc_seq,
  input  logic       word_end,
  input  logic       seq_valid,
  output logic       seq_ready,
  output logic       key,
  output logic       busy,
  output logic       done
);

  // Terminal counts: each timed state runs while the counter goes 0..LAST.
  localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(7 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_GAP   = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [9:0]       seq_reg, seq_next;
  logic             word_reg, word_next;
  logic             key_reg, key_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // Slot lookup table padded to 8 entries so that the index past the last
  // slot (5) reads as empty and naturally terminates the letter.
  logic [1:0] slot_arr [0:7];
  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    if (gi < 5) begin : g_real
      assign slot_arr[gi] = seq_reg[9 - 2*gi -: 2];
    end else begin : g_pad
      assign slot_arr[gi] = 2'b11;
    end
  end

  logic [1:0]       cur_slot;
  logic [1:0]       nxt_slot;
  logic [CNT_W-1:0] mark_last;
  logic [CNT_W-1:0] trail_last_next;

  assign cur_slot  = slot_arr[idx_reg];
  assign nxt_slot  = slot_arr[idx_reg + 3'd1];
  assign mark_last = cur_slot[0] ? DASH_LAST : DOT_LAST;
  // Trail length is judged against the word flag being loaded, so the done
  // flag can be registered together with the state it belongs to.
  assign trail_last_next = word_next ? WORD_LAST : DASH_LAST;

  assign seq_ready = (state_reg == ST_IDLE) & ~clear;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    seq_next   = seq_reg;
    word_next  = word_reg;

    if (clear) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      idx_next   = '0;
      seq_next   = '0;
      word_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_next = '0;
          idx_next = '0;
          if (seq_valid) begin
            seq_next   = enc_seq;
            word_next  = word_end;
            state_next = enc_seq[9] ? ST_TRAIL : ST_MARK;
          end
        end
        ST_MARK: begin
          if (cnt_reg == mark_last) begin
            cnt_next   = '0;
            state_next = nxt_slot[1] ? ST_TRAIL : ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_reg == DOT_LAST) begin
            cnt_next   = '0;
            idx_next   = idx_reg + 3'd1;
            state_next = ST_MARK;
          end
        end
        default: begin // ST_TRAIL
          if (cnt_reg == (word_reg ? WORD_LAST : DASH_LAST)) begin
            cnt_next   = '0;
            idx_next   = '0;
            state_next = ST_IDLE;
          end
        end
      endcase
    end

    key_next  = (state_next == ST_MARK);
    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_TRAIL) && (cnt_next == trail_last_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      seq_reg   <= '0;
      word_reg  <= 1'b0;
      key_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      seq_reg   <= seq_next;
      word_reg  <= word_next;
      key_reg   <= key_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign key  = key_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_morse_sequence_keyer.sv
module tb_morse_sequence_keyer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] enc_seq = '0;
  logic       word_end = 1'b0;
  logic       seq_valid = 1'b0;
  logic       seq_ready, key, busy, done;

  int compared = 0;
  int mismatched = 0;

  morse_sequence_keyer #(.UNIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enc_seq(enc_seq),
    .word_end(word_end), .seq_valid(seq_valid), .seq_ready(seq_ready),
    .key(key), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expand alternating run lengths (first run is key-on) into a per-cycle
  // key vector, bit i = key on cycle i+1 after the accept edge.
  function automatic logic [63:0] pattern(input int runs[$]);
    logic [63:0] v = '0;
    int pos = 0;
    logic on = 1'b1;
    foreach (runs[i]) begin
      for (int j = 0; j < runs[i]; j++) begin
        v[pos] = on;
        pos++;
      end
      on = ~on;
    end
    return v;
  endfunction

  // Accept one sequence, record the key waveform until done (bounded), and
  // compare against the expected waveform and length.
  task automatic run_seq(input string name, input logic [9:0] enc, input logic wend,
                         input logic [63:0] exp_key, input int exp_len, input int glitch_at);
    logic [63:0] keys = '0;
    int busy_cnt = 0, done_cnt = 0, done_at = 0, ready_bad = 0, cyc = 0;
    bit fin = 0;
    @(negedge clk);
    check({name, "_ready_before"}, 64'(seq_ready), 64'd1);
    enc_seq = enc; word_end = wend; seq_valid = 1'b1;
    @(negedge clk);
    seq_valid = 1'b0; enc_seq = ~enc; word_end = ~wend;
    while (!fin && cyc < 100) begin
      cyc++;
      if (cyc <= 64) keys[cyc-1] = key;
      if (busy) busy_cnt++;
      if (busy && seq_ready) ready_bad++;
      if (done) begin done_cnt++; done_at = cyc; fin = 1; end
      if (cyc == glitch_at) begin
        seq_valid = 1'b1; enc_seq = 10'b01_01_01_01_01;
      end else begin
        seq_valid = 1'b0;
      end
      if (!fin) @(negedge clk);
    end
    seq_valid = 1'b0;
    check({name, "_finished"}, 64'(fin), 64'd1);
    check({name, "_key_pattern"}, keys, exp_key);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_len));
    check({name, "_done_cycle"}, 64'(done_at), 64'(exp_len));
    check({name, "_done_count"}, 64'(done_cnt), 64'd1);
    check({name, "_ready_while_busy"}, 64'(ready_bad), 64'd0);
    @(negedge clk);
    check({name, "_ready_after"}, 64'(seq_ready), 64'd1);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    check({name, "_done_after"}, 64'(done), 64'd0);
  endtask

  initial begin
    int runs[$];
    int dones;

    // Reset state
    #12;
    check("reset_key", 64'(key), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 64'(seq_ready), 64'd1);

    // Clear has priority over accept
    @(negedge clk);
    clear = 1'b1; seq_valid = 1'b1; enc_seq = 10'b00_00_00_00_00;
    #1;
    check("clear_ready_low", 64'(seq_ready), 64'd0);
    @(negedge clk);
    clear = 1'b0; seq_valid = 1'b0;
    check("clear_accept_busy", 64'(busy), 64'd0);
    check("clear_accept_key", 64'(key), 64'd0);
    @(negedge clk);
    check("clear_accept_busy2", 64'(busy), 64'd0);

    runs = '{2, 2, 6, 2, 2, 2, 2, 2, 6, 6};
    run_seq("seq_mixed", 10'b00_01_00_00_01, 1'b0, pattern(runs), 32, 0);

    runs = '{0, 14};
    run_seq("seq_empty", 10'b11_11_11_11_11, 1'b1, pattern(runs), 14, 0);

    runs = '{2, 2, 2, 2, 2, 2, 6, 2, 6, 14};
    run_seq("seq_word", 10'b00_00_00_01_01, 1'b1, pattern(runs), 40, 5);

    runs = '{6, 6};
    run_seq("seq_term", 10'b01_11_00_00_00, 1'b0, pattern(runs), 12, 0);

    // Clear on the third cycle of a dash
    @(negedge clk);
    enc_seq = 10'b01_11_11_11_11; word_end = 1'b0; seq_valid = 1'b1;
    @(negedge clk);
    seq_valid = 1'b0;
    check("clr_mark_c1", 64'(key), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("clr_mark_c3", 64'(key), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    check("clr_key", 64'(key), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    clear = 1'b0;
    #1;
    check("clr_ready", 64'(seq_ready), 64'd1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("clr_no_done", 64'(dones), 64'd0);

    // Async reset mid-mark: outputs drop without a clock edge
    @(negedge clk);
    enc_seq = 10'b01_11_11_11_11; word_end = 1'b1; seq_valid = 1'b1;
    @(negedge clk);
    seq_valid = 1'b0;
    @(negedge clk);
    check("rst_mark_key", 64'(key), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_key", 64'(key), 64'd0);
    check("rst_async_busy", 64'(busy), 64'd0);
    check("rst_async_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(seq_ready), 64'd1);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || key) dones++;
    end
    check("rst_quiet", 64'(dones), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/morse_sequence_keyer.md
Name: morse_sequence_keyer

Overview:
- Transmit-side counterpart of the sequence producer/separator path: converts one 10-bit encoded Morse sequence back into a timed on/off key signal.
- Accepts a sequence via valid/ready handshake, plays its elements with standard unit timing, then applies the trailing letter or word gap.
- Feeds the tone/LED driver; upstream is the sequence buffer holding separated sequences.

Parameters:
- UNIT_CYCLES, 4, clock cycles per Morse time unit (legal range ≥1).
- CNT_W, derived as clog2(7*UNIT_CYCLES+1), width of the unit-cycle counter.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Clear  input  1  synchronous abort; returns the block to IDLE.
- EncSeq  input  10  five 2-bit slots. Slot0 = [9:8] is sent first, slot4 = [1:0] last. Codes: 00 = dot, 01 = dash, 1x = empty.
- WordEnd  input  1  sampled with EncSeq. 1 = word gap follows (Space), 0 = letter gap follows (EndSeq).
- SeqValid  input  1  EncSeq/WordEnd valid.
- SeqReady  output  1  block can accept a sequence.
- Key  output  1  1 = tone on (mark).
- Busy  output  1  a sequence is in progress.
- Done  output  1  one-cycle pulse on the final trailing-gap cycle.

Behaviour:
- Reset low (async): state IDLE; Key=0, Busy=0, Done=0; slot index and counter = 0; SeqReady=1 once Reset is high.
- SeqReady = (state==IDLE) & ~Clear. Accept occurs when SeqValid & SeqReady are both high at a rising edge; EncSeq and WordEnd are latched internally then.
- SeqValid is ignored while Busy. EncSeq may change after acceptance.
- FSM states:
  - IDLE. On accept:
    - slot0 non-empty → MARK (slot index 0).
    - slot0 empty → TRAIL.
  - MARK. Key=1 for exactly UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash) cycles. When done:
    - next slot exists (index<4) and is non-empty → GAP.
    - otherwise → TRAIL.
  - GAP. Key=0 for UNIT_CYCLES cycles, then index+1 → MARK.
  - TRAIL. Key=0 for 3*UNIT_CYCLES cycles (WordEnd=0) or 7*UNIT_CYCLES cycles (WordEnd=1). Done=1 on its last cycle, then → IDLE.
- Latency: the first Key=1 or TRAIL cycle is the cycle immediately after the accept edge. Busy=1 from that cycle through the Done cycle, inclusive.
- Back-to-back: SeqReady rises the cycle after Done. The next mark therefore starts 2 cycles after the Done cycle at the earliest.
- Sequence termination: the first empty slot ends the letter; later slots are ignored even if they hold dot/dash codes.
- All-empty sequence: no marks; silent TRAIL only (3 or 7 units), Done still pulses.
- Key is registered and glitch-free. Key=1 only in MARK.
- Clear=1 at any edge: next cycle state=IDLE, Key=0, Busy=0, no Done pulse, latched sequence discarded. Clear has priority over accept in the same cycle.
- Reset low mid-operation: outputs drop immediately (async), no Done pulse.

Test Plan (UNIT_CYCLES=2):
- Reset low then high → Key=0, Busy=0, Done=0, SeqReady=1; SeqValid pulse with Clear=1 is not accepted.
- Accept EncSeq=10'b00_01_00_00_01, WordEnd=0 → Key pattern 2 on, 2 off, 6 on, 2 off, 2 on, 2 off, 2 on, 2 off, 6 on, then 6 off. Busy high 32 cycles; Done on the 32nd cycle; SeqReady high the next cycle.
- Accept EncSeq=10'b11_11_11_11_11, WordEnd=1 → Key stays 0; Busy high 14 cycles; Done on the 14th cycle.
- Accept EncSeq=10'b00_00_00_01_01, WordEnd=1 → marks 2,2,2,6,6 separated by 2-cycle gaps, then 14 off; Busy 40 cycles. A SeqValid pulse during Busy leaves the pattern unchanged.
- Accept EncSeq=10'b01_11_00_00_00 → one 6-cycle mark then a 6-cycle gap (trailing 00 slots ignored); Busy 12 cycles.
- Assert Clear on the 3rd cycle of a dash → Key=0, Busy=0, SeqReady=1 the next cycle, no Done. Repeat with Reset low mid-mark → Key drops without a clock edge.
